// File: rtl/meas_tx.sv
// Measurement-frame transmitter: snapshots the payload and mode on start, then
// streams SYNC, TYPE, LEN, payload and checksum bytes into the FT245 write FIFO.
module meas_tx #(
  parameter int          N_BYTES   = 98,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter logic [3:0]  TYPE_HI   = 4'h5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [8*N_BYTES-1:0] meas_data,
  input  logic [3:0]           op_mode,
  input  logic                 wr_full,
  output logic                 wr_en,
  output logic [7:0]           wr_data,
  output logic                 busy,
  output logic                 done,
  output logic                 drop
);

  localparam int         IW       = $clog2(8*N_BYTES);
  localparam logic [7:0] LEN_BYTE = 8'(N_BYTES);
  localparam logic [7:0] LAST_IDX = 8'(N_BYTES-1);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_TYPE, S_LEN, S_PAYLOAD, S_CHK, S_DONE
  } state_t;

  state_t               state, state_nxt;
  logic [8*N_BYTES-1:0] snap_data;
  logic [3:0]           snap_mode;
  logic [7:0]           acc, acc_nxt;
  logic [7:0]           idx, idx_nxt;
  logic                 load;
  logic [IW-1:0]        bit_sel;
  logic [7:0]           pay_byte;
  logic [7:0]           type_byte;

  assign bit_sel   = IW'({idx, 3'b000});
  assign pay_byte  = snap_data[bit_sel +: 8];
  assign type_byte = {TYPE_HI, snap_mode};

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    idx_nxt   = idx;
    load      = 1'b0;
    done      = 1'b0;
    wr_data   = 8'h00;
    busy      = (state inside {S_SYNC, S_TYPE, S_LEN, S_PAYLOAD, S_CHK});
    wr_en     = busy && !wr_full;
    case (state)
      S_IDLE: if (start) begin
        load      = 1'b1;
        acc_nxt   = 8'h00;
        idx_nxt   = 8'h00;
        state_nxt = S_SYNC;
      end
      S_SYNC: begin
        wr_data = SYNC_BYTE;
        if (wr_en) state_nxt = S_TYPE;
      end
      S_TYPE: begin
        wr_data = type_byte;
        if (wr_en) begin
          acc_nxt   = acc + type_byte;
          state_nxt = S_LEN;
        end
      end
      S_LEN: begin
        wr_data = LEN_BYTE;
        if (wr_en) begin
          acc_nxt   = acc + LEN_BYTE;
          state_nxt = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        wr_data = pay_byte;
        if (wr_en) begin
          acc_nxt = acc + pay_byte;
          idx_nxt = idx + 8'd1;
          if (idx == LAST_IDX) state_nxt = S_CHK;
        end
      end
      S_CHK: begin
        // Two's complement makes the sum of TYPE..CHK wrap to zero.
        wr_data = 8'h00 - acc;
        if (wr_en) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      acc       <= 8'h00;
      idx       <= 8'h00;
      snap_data <= '0;
      snap_mode <= 4'h0;
      drop      <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      idx   <= idx_nxt;
      drop  <= start && (state != S_IDLE);
      if (load) begin
        snap_data <= meas_data;
        snap_mode <= op_mode;
      end
    end
  end

endmodule
